// File: rtl/fft_bfly_sched.sv
// Radix-2 DIT butterfly issue sequencer: walks (stage, butterfly) pairs, emits one
// descriptor per handshake and holds a write-back barrier between stages.
module fft_bfly_sched #(
    parameter int LOGN = 8
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            Start,
    input  logic            Ack,
    input  logic            Issue_Ready,
    input  logic            Wb_Valid,
    output logic            Issue_Valid,
    output logic [LOGN-1:0] I_Top,
    output logic [LOGN-1:0] I_Bot,
    output logic [LOGN-2:0] Tw_Idx,
    output logic [3:0]      Stage,
    output logic            Busy,
    output logic            Done,
    output logic            Err,
    output logic [3:0]      State
);
    typedef enum logic [3:0] {
        IDLE  = 4'b0001,
        ISSUE = 4'b0010,
        DRAIN = 4'b0100,
        DONE  = 4'b1000
    } state_t;

    localparam logic [3:0] LAST_S = 4'(LOGN - 1);

    state_t          state_q, state_d;
    logic [3:0]      s_q, s_d;
    logic [LOGN-2:0] k_q, k_d;
    logic [LOGN-1:0] o_q, o_d;
    logic            err_q, err_d;
    logic            armed_q, armed_d;
    logic            iv_q, busy_q, done_q;
    logic [LOGN-1:0] top_q, bot_q;
    logic [LOGN-2:0] tw_q;
    logic [3:0]      stg_q;
    logic            xfer, wb_acc;
    logic [LOGN-1:0] kk, half, pos, top_n, bot_n;
    logic [LOGN-2:0] tw_n;

    // Descriptor for the next (s, k) so it is registered together with the state.
    always_comb begin
        kk    = {1'b0, k_d};
        half  = LOGN'(1) << s_d;
        pos   = kk & (half - LOGN'(1));
        top_n = ((kk >> s_d) << (s_d + 4'd1)) | pos;
        bot_n = top_n + half;
        tw_n  = pos[LOGN-2:0] << (LAST_S - s_d);
    end

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        k_d     = k_q;
        o_d     = o_q;
        err_d   = err_q;
        armed_d = armed_q;
        xfer    = iv_q & Issue_Ready;
        // Write-backs after a reset abort belong to a dead run; drop them until Start.
        wb_acc  = Wb_Valid & armed_q;

        if (xfer && !wb_acc) begin
            o_d = o_q + LOGN'(1);
        end else if (!xfer && wb_acc) begin
            if (o_q == '0) err_d = 1'b1;
            else           o_d   = o_q - LOGN'(1);
        end

        case (state_q)
            IDLE: begin
                if (Start) begin
                    s_d     = '0;
                    k_d     = '0;
                    o_d     = '0;
                    err_d   = 1'b0;
                    armed_d = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (xfer) begin
                    if (&k_q) begin
                        k_d     = '0;
                        state_d = DRAIN;
                    end else begin
                        k_d = k_q + (LOGN-1)'(1);
                    end
                end
            end
            DRAIN: begin
                if (o_d == '0) begin
                    if (s_q != LAST_S) begin
                        s_d     = s_q + 4'd1;
                        state_d = ISSUE;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (Ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            s_q     <= '0;
            k_q     <= '0;
            o_q     <= '0;
            err_q   <= 1'b0;
            armed_q <= 1'b0;
            iv_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            top_q   <= '0;
            bot_q   <= '0;
            tw_q    <= '0;
            stg_q   <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            k_q     <= k_d;
            o_q     <= o_d;
            err_q   <= err_d;
            armed_q <= armed_d;
            iv_q    <= (state_d == ISSUE);
            busy_q  <= (state_d == ISSUE) || (state_d == DRAIN);
            done_q  <= (state_d == DONE);
            if (state_d == ISSUE) begin
                top_q <= top_n;
                bot_q <= bot_n;
                tw_q  <= tw_n;
                stg_q <= s_d;
            end
        end
    end

    assign Issue_Valid = iv_q;
    assign I_Top       = top_q;
    assign I_Bot       = bot_q;
    assign Tw_Idx      = tw_q;
    assign Stage       = stg_q;
    assign Busy        = busy_q;
    assign Done        = done_q;
    assign Err         = err_q;
    assign State       = state_q;
endmodule

// File: doc/fft_bfly_sched.md
Name: fft_bfly_sched

Overview:
- Sequencer for an in-place radix-2 DIT FFT over the shared X_Re/X_Im sample memory.
- After Start, issues one butterfly descriptor (top index, bottom index, twiddle index, stage) per accepted handshake to the butterfly datapath.
- Tracks in-flight butterflies and holds a barrier between stages, so stage s+1 never reads data that stage s has not yet written back.
- Sits between the top-level FFT state machine (Start/Done/Ack) and the butterfly/write-back unit. Input is in bit-reversed order (handled upstream).

Parameters:
- LOGN, 8, log2 of transform size N (N = 2^LOGN, legal range 2..10).

Ports:
- Clk  in  1  clock; all logic on posedge.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  begin a transform; sampled only in IDLE.
- Ack  in  1  acknowledges Done; returns the block to IDLE.
- Issue_Ready  in  1  butterfly datapath can accept a descriptor.
- Wb_Valid  in  1  one-cycle pulse per completed butterfly write-back.
- Issue_Valid  out  1  descriptor on I_Top/I_Bot/Tw_Idx/Stage is valid.
- I_Top  out  LOGN  top operand address.
- I_Bot  out  LOGN  bottom operand address.
- Tw_Idx  out  LOGN-1  twiddle ROM index (W_N^Tw_Idx).
- Stage  out  4  current stage, 0..LOGN-1.
- Busy  out  1  high in ISSUE or DRAIN.
- Done  out  1  high in DONE.
- Err  out  1  sticky: Wb_Valid received with zero butterflies outstanding.
- State  out  4  one-hot state, for debug/SSD display.

Behaviour:
- States (one-hot): IDLE=4'b0001, ISSUE=4'b0010, DRAIN=4'b0100, DONE=4'b1000. Any other encoding goes to IDLE next cycle.
- Reset:
  - State=IDLE; stage counter s=0; butterfly counter k=0; outstanding count o=0.
  - All outputs 0 except State=4'b0001.
  - Reset mid-operation aborts immediately. Any later Wb_Valid is ignored until the next Start and does not set Err.
- IDLE:
  - Start=1 clears s, k, o and Err, then moves to ISSUE next cycle.
  - Ack is ignored.
- ISSUE:
  - Issue_Valid=1. Descriptor is a registered function of (s, k):
    - half = 1<<s, pos = k & (half-1), grp = k >> s.
    - I_Top = grp*2*half + pos.
    - I_Bot = I_Top + half.
    - Tw_Idx = pos << (LOGN-1-s).
    - Stage = s.
  - Transfer occurs on Issue_Valid & Issue_Ready.
  - Without a transfer, the descriptor holds stable and Issue_Valid stays 1 (no retraction).
  - On transfer:
    - o increments.
    - If k < N/2-1: k increments and the next descriptor appears the following cycle, so back-to-back issue is 1 per cycle.
    - If k = N/2-1: k resets to 0 and the state moves to DRAIN; Issue_Valid=0 from the next cycle.
- DRAIN:
  - Issue_Valid=0. Wait until o=0, including o reaching 0 this cycle.
  - Then, if s < LOGN-1: s increments and the state returns to ISSUE.
  - Otherwise the state moves to DONE.
  - DRAIN lasts at least 1 cycle even if o is already 0.
- DONE:
  - Done=1 until Ack=1, then IDLE next cycle.
  - Start is ignored in DONE.
- Outstanding counter:
  - Width LOGN bits; maximum value N/2.
  - A transfer and a Wb_Valid in the same cycle leave o unchanged.
  - Wb_Valid with o=0 and no transfer that cycle sets Err; o stays 0 (no underflow).
- Busy = ISSUE | DRAIN.

Test Plan:
- Index sequence, LOGN=3, Issue_Ready=1, Wb_Valid returned 2 cycles after each transfer:
  - Stage 0 (I_Top,I_Bot,Tw): (0,1,0) (2,3,0) (4,5,0) (6,7,0).
  - Stage 1: (0,2,0) (1,3,2) (4,6,0) (5,7,2).
  - Stage 2: (0,4,0) (1,5,1) (2,6,2) (3,7,3).
  - Done asserts after exactly 12 transfers.
- Stage barrier, LOGN=3, write-back latency 10: no stage-1 transfer until the 4th stage-0 Wb_Valid has been seen; Busy stays 1 throughout.
- Backpressure: Issue_Ready toggled pseudo-randomly → descriptor is unchanged while Issue_Valid&!Issue_Ready; no descriptor is skipped or duplicated; LOGN=8 completes 1024 transfers.
- Simultaneous events: a transfer coinciding with Wb_Valid leaves o unchanged; a spurious Wb_Valid in IDLE after a completed run sets Err=1; a following Start clears it.
- Reset mid-run: Reset asserted in stage 1 of LOGN=3 → next cycle State=4'b0001, Issue_Valid=0, Done=0; a fresh Start replays stage 0 from (0,1,0).
- Done/Ack: Start pulsed in DONE is ignored; Ack=1 → IDLE next cycle; Start then begins a new run.
